// File: rtl/io_mmio_ctrl_pkg.sv
// io_mmio_ctrl_pkg: shared I/O address map, write-target decode and helpers
// for the memory-mapped I/O controller.
//   IO_*_ADDR  - byte addresses of the I/O registers
//   One_Sec    - clock cycles in one second at the board clock
//   decode_wr  - maps a store address onto the register it targets
//   io_in_addr - address of latched input channel k
package io_mmio_ctrl_pkg;

  localparam logic [31:0] IO_SEG_ADDR   = 32'hFFFF_0000;
  localparam logic [31:0] IO_LED_ADDR   = 32'hFFFF_0004;
  localparam logic [31:0] IO_BLINK_ADDR = 32'hFFFF_0008;
  localparam logic [31:0] IO_STAT_ADDR  = 32'hFFFF_000C;
  localparam logic [31:0] IO_TEST_ADDR  = 32'hFFFF_0010;
  localparam logic [31:0] IO_IN_BASE    = 32'hFFFF_0020;

  localparam int unsigned One_Sec = 100_000_000;

  typedef enum logic [2:0] {
    WrNone,
    WrSeg,
    WrLed,
    WrBlink,
    WrStat
  } io_wr_sel_e;

  function automatic io_wr_sel_e decode_wr(input logic [31:0] addr);
    case (addr)
      IO_SEG_ADDR:   return WrSeg;
      IO_LED_ADDR:   return WrLed;
      IO_BLINK_ADDR: return WrBlink;
      IO_STAT_ADDR:  return WrStat;
      default:       return WrNone;
    endcase
  endfunction

  function automatic logic [31:0] io_in_addr(input int unsigned k);
    return IO_IN_BASE + 32'(k * 4);
  endfunction

endpackage

// File: rtl/io_mmio_ctrl_if.sv
// io_mmio_ctrl_if: CPU load/store side of the I/O controller.
//   io_read   - load targets I/O space this cycle
//   io_write  - store targets I/O space this cycle (one cycle per store)
//   addr      - byte address (ALU result)
//   wdata     - store data
//   mem_rdata - data-memory read data
//   rdata     - merged memory/I/O load result (combinational)
interface io_mmio_ctrl_if;
  logic        io_read;
  logic        io_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] mem_rdata;
  logic [31:0] rdata;

  modport master (
    output io_read,
    output io_write,
    output addr,
    output wdata,
    output mem_rdata,
    input  rdata
  );

  modport slave (
    input  io_read,
    input  io_write,
    input  addr,
    input  wdata,
    input  mem_rdata,
    output rdata
  );
endinterface

// File: rtl/io_mmio_ctrl_disp_fifo.sv
// disp_fifo: synchronous FIFO holding pending seven-segment display words.
//   i_clk/i_rst  - clock, synchronous active-high reset
//   i_clr        - empties the FIFO (wins over a same-cycle push)
//   i_push       - write i_wdata; accepted when not full or when popping
//   i_pop        - drop the head entry; ignored when empty
//   o_head       - current head entry
//   o_count      - occupancy 0..DEPTH
//   o_full/o_empty
module disp_fifo
  import io_mmio_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned DEPTH  = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clr,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [DATA_W-1:0]        i_wdata,
  output logic [DATA_W-1:0]        o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]   r_wr_ptr;
  logic [PtrW-1:0]   r_rd_ptr;
  logic [CntW-1:0]   r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_full  = (r_count == CntW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers are PtrW bits wide, so they wrap modulo DEPTH by themselves.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/io_mmio_ctrl.sv
// io_mmio_ctrl: memory-mapped I/O controller between the CPU load/store path
// and the board peripherals.
//   i_clk/i_rst - clock, synchronous active-high reset
//   bus         - CPU load/store signals (slave side)
//   i_sw_in     - raw switch bus shared by all input channels
//   i_enter     - per-channel capture strobes (already synchronised)
//   i_test_in   - test-case selector switches
//   o_seg_out   - current display word, 0 while the display FIFO is empty
//   o_led_out   - LED register
//   o_blink_out - high while the blink timer runs
module io_mmio_ctrl
  import io_mmio_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W       = 24,
  parameter int unsigned DEPTH        = 32,
  parameter int unsigned DWELL_CYCLES = One_Sec,
  parameter int unsigned N_IN         = 2,
  parameter int unsigned IN_W         = 8,
  parameter int unsigned TEST_W       = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  io_mmio_ctrl_if.slave        bus,
  input  logic [IN_W-1:0]      i_sw_in,
  input  logic [N_IN-1:0]      i_enter,
  input  logic [TEST_W-1:0]    i_test_in,
  output logic [DATA_W-1:0]    o_seg_out,
  output logic [DATA_W-1:0]    o_led_out,
  output logic                 o_blink_out
);

  localparam int unsigned CntW   = $clog2(DEPTH) + 1;
  localparam int unsigned DwellW = $clog2(DWELL_CYCLES + 1);
  localparam logic [DwellW-1:0] DwellLast = DwellW'(DWELL_CYCLES - 1);

  io_wr_sel_e        w_wr_sel;
  logic              w_seg_push;
  logic              w_clr;
  logic              w_pop;
  logic [DATA_W-1:0] w_head;
  logic [CntW-1:0]   w_count;
  logic              w_full;
  logic              w_empty;

  logic [DATA_W-1:0] r_led;
  logic [31:0]       r_blink_cnt;
  logic [DwellW-1:0] r_dwell_cnt;
  logic              r_ovf;
  logic [IN_W-1:0]   r_chan [N_IN];

  assign w_wr_sel   = bus.io_write ? decode_wr(bus.addr) : WrNone;
  assign w_seg_push = (w_wr_sel == WrSeg);
  assign w_clr      = (w_wr_sel == WrStat);

  // The head has been on show for DWELL_CYCLES cycles once the counter
  // reaches DWELL_CYCLES-1 at an edge.
  assign w_pop = !w_empty && (r_dwell_cnt == DwellLast);

  disp_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_disp_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (w_clr),
    .i_push  (w_seg_push),
    .i_pop   (w_pop),
    .i_wdata (bus.wdata[DATA_W-1:0]),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_led       <= '0;
      r_blink_cnt <= '0;
      r_dwell_cnt <= '0;
      r_ovf       <= 1'b0;
      for (int unsigned k = 0; k < N_IN; k++) begin
        r_chan[k] <= '0;
      end
    end else begin
      if (w_wr_sel == WrLed) begin
        r_led <= bus.wdata[DATA_W-1:0];
      end

      // A write reloads (or, with 0, cancels) the timer; otherwise count down.
      if (w_wr_sel == WrBlink) begin
        r_blink_cnt <= bus.wdata;
      end else if (r_blink_cnt != '0) begin
        r_blink_cnt <= r_blink_cnt - 32'd1;
      end

      if (w_clr) begin
        r_dwell_cnt <= '0;
        r_ovf       <= 1'b0;
      end else begin
        // Held at 0 while empty so a newly pushed word gets a full dwell.
        if (w_empty || w_pop) begin
          r_dwell_cnt <= '0;
        end else begin
          r_dwell_cnt <= r_dwell_cnt + DwellW'(1);
        end
        if (w_seg_push && w_full && !w_pop) begin
          r_ovf <= 1'b1;
        end
      end

      for (int unsigned k = 0; k < N_IN; k++) begin
        if (i_enter[k]) begin
          r_chan[k] <= i_sw_in;
        end
      end
    end
  end

  assign o_seg_out   = w_empty ? '0 : w_head;
  assign o_led_out   = r_led;
  assign o_blink_out = (r_blink_cnt != '0);

  always_comb begin
    bus.rdata = bus.mem_rdata;
    if (bus.io_read) begin
      if (bus.addr == IO_TEST_ADDR) begin
        bus.rdata = 32'(i_test_in);
      end else if (bus.addr == IO_STAT_ADDR) begin
        bus.rdata = 32'({w_count, r_ovf, w_full, w_empty});
      end
      for (int unsigned k = 0; k < N_IN; k++) begin
        if (bus.addr == io_in_addr(k)) begin
          bus.rdata = 32'(r_chan[k]);
        end
      end
    end
  end

endmodule
